// File: rtl/rv_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rv_core_pkg                                                |
// | Shared core constants and the register-file dump state encoding.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package rv_core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_dump_reader                                             |
// | Sweeps a register-file address range through an asynchronous read    |
// | port, streams (address, data) beats on valid/ready and keeps an XOR  |
// | checksum of every accepted beat.                                     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rf_dump_reader
  import rv_core_pkg::*;
#(
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = XLEN,
  parameter int ZERO_X0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DATA_W-1:0] checksum
);

  dump_state_e       r_state;
  dump_state_e       w_next;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_last;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [DATA_W-1:0] r_checksum;
  logic              r_err;

  logic              w_range_ok;
  logic              w_fire;
  logic [DATA_W-1:0] w_word;

  assign w_range_ok = (first_addr <= last_addr);
  assign w_fire     = (r_state == SEND) && r_out_valid && out_ready;
  // x0 reads as zero architecturally even if the array cell holds junk
  assign w_word     = ((ZERO_X0 != 0) && (r_cur == '0)) ? '0 : rf_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_range_ok ? FETCH : DONE;
        end
      end
      FETCH: w_next = SEND;
      SEND: begin
        if (w_fire) begin
          w_next = r_out_last ? DONE : FETCH;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Range cursor, beat capture, checksum and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur       <= '0;
      r_last      <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_checksum  <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && w_range_ok) begin
            r_cur      <= first_addr;
            r_last     <= last_addr;
            r_checksum <= '0;
            r_err      <= 1'b0;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        FETCH: begin
          r_out_data  <= w_word;
          r_out_addr  <= r_cur;
          r_out_last  <= (r_cur == r_last);
          r_out_valid <= 1'b1;
        end
        SEND: begin
          if (w_fire) begin
            r_checksum  <= r_checksum ^ r_out_data;
            r_out_valid <= 1'b0;
            // The final beat leaves the cursor alone, so a top-of-range
            // dump never wraps back to zero.
            if (!r_out_last) begin
              r_cur <= r_cur + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign err       = r_err;
  // The cursor only moves on accept or after a beat, so it also holds
  // the last driven read address outside FETCH.
  assign rf_addr   = r_cur;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign checksum  = r_checksum;

endmodule
`default_nettype wire
